// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: run/step/halt controller for the MIPS core clock-enable.
// A programmable divider paces a one-cycle cpu_en pulse: one pulse every
// div_r clocks while in RUN, or exactly one pulse per step_req rising edge
// accepted in IDLE (STEP). halt_req forces HALTED from any state.
//
// Optional feature: define CYCLE_COUNT_EN to add the cycle_cnt output, a
// CNT_W-bit wrapping count of issued cpu_en pulses (cleared only by reset).
module cpu_step_ctrl #(
  parameter int DIV_W       = 16,
  parameter int DIV_DEFAULT = 10,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_req,
  input  logic             step_req,
  input  logic             halt_req,
  input  logic             div_ld,
  input  logic [DIV_W-1:0] div_val,
  output logic             cpu_en,
  output logic             busy,
  output logic             halted,
  output logic [1:0]       state_o
`ifdef CYCLE_COUNT_EN
  ,
  output logic [CNT_W-1:0] cycle_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    STEP   = 2'b10,
    HALTED = 2'b11
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cnt_nxt;
  logic [DIV_W-1:0] div_r;
  logic             step_d;
  logic             step_edge;
  logic             active;
  logic             tick;
  logic             pulse_nxt;

  // Next-state, divider tick and pulse decision; halt beats run beats step.
  always_comb begin
    state_nxt = state;
    step_edge = step_req & ~step_d;
    active    = (state == RUN) || (state == STEP);
    // div_r is never zero, so div_r-1 is the last count of each period.
    tick      = active && (cnt == (div_r - DIV_W'(1)));

    case (state)
      IDLE: begin
        if (halt_req)       state_nxt = HALTED;
        else if (run_req)   state_nxt = RUN;
        else if (step_edge) state_nxt = STEP;
      end
      RUN: begin
        if (halt_req)      state_nxt = HALTED;
        else if (!run_req) state_nxt = IDLE;
      end
      STEP: begin
        // run_req has no say here; the step either completes or is aborted.
        if (halt_req)  state_nxt = HALTED;
        else if (tick) state_nxt = IDLE;
      end
      HALTED: begin
        if (!halt_req && !run_req) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // A pulse is issued only when the period ends without leaving RUN, or
    // when the single step completes; any abort or exit edge drops it.
    pulse_nxt = tick && (((state == RUN) && (state_nxt == RUN)) ||
                         ((state == STEP) && (state_nxt == IDLE)));

    // The counter restarts on any state change, so every RUN/STEP entry
    // sees a full div_r period before its first pulse.
    if (!active || (state_nxt != state) || tick) cnt_nxt = '0;
    else                                           cnt_nxt = cnt + DIV_W'(1);
  end

  // State register, divider counter, registered enable and step edge history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      cpu_en <= 1'b0;
      step_d <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      cpu_en <= pulse_nxt;
      step_d <= step_req;
    end
  end

  // Divisor register: writable only while the core is not being clocked; a
  // zero divisor is promoted to 1 (enable every cycle).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_r <= DIV_W'(DIV_DEFAULT);
    end else if (div_ld && !active) begin
      div_r <= (div_val == '0) ? DIV_W'(1) : div_val;
    end
  end

`ifdef CYCLE_COUNT_EN
  // Issued-pulse counter; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt <= '0;
    end else if (cpu_en) begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
    end
  end
`endif

  assign state_o = state;
  assign busy    = (state == RUN) || (state == STEP);
  assign halted  = (state == HALTED);

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Testbench for cpu_step_ctrl: directed scenarios plus randomized stimulus,
// checked through a scoreboard fed by a behavioural model of the controller.
module tb_cpu_step_ctrl;

  localparam int DIV_W = 16;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             run_req;
  logic             step_req;
  logic             halt_req;
  logic             div_ld;
  logic [DIV_W-1:0] div_val;
  logic             cpu_en;
  logic             busy;
  logic             halted;
  logic [1:0]       state_o;
`ifdef CYCLE_COUNT_EN
  logic [CNT_W-1:0] cycle_cnt;
`endif

  cpu_step_ctrl #(
    .DIV_W      (DIV_W),
    .DIV_DEFAULT(10),
    .CNT_W      (CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .run_req  (run_req),
    .step_req (step_req),
    .halt_req (halt_req),
    .div_ld   (div_ld),
    .div_val  (div_val),
    .cpu_en   (cpu_en),
    .busy     (busy),
    .halted   (halted),
    .state_o  (state_o)
`ifdef CYCLE_COUNT_EN
    ,
    .cycle_cnt(cycle_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference model: operating mode, pulse period, and the number of clock
  // edges spent in the current RUN/STEP stint.
  typedef enum {M_IDLE, M_RUN, M_STEP, M_HALT} mode_t;

  mode_t            m_mode;
  int               m_div;
  bit               m_step_prev;
  int               m_age;
  logic [CNT_W-1:0] m_pulses;

  function automatic logic [1:0] mode_code(mode_t m);
    case (m)
      M_RUN:   return 2'b01;
      M_STEP:  return 2'b10;
      M_HALT:  return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  task automatic model_reset();
    m_mode      = M_IDLE;
    m_div       = 10;
    m_step_prev = 1'b0;
    m_age       = 0;
    m_pulses    = '0;
  endtask

  typedef struct {
    int               due;
    bit               en;
    logic [1:0]       st;
    logic [CNT_W-1:0] cc;
  } exp_t;

  exp_t q[$];

  // Drive one cycle of inputs, predict the outputs after the next edge.
  task automatic cycle(input bit r, input bit s, input bit h, input bit l, input int v);
    exp_t  e;
    bit    edge_s;
    bit    pulse;
    mode_t nm;
    int    a1;
    @(posedge clk);
    #1;
    run_req  = r;
    step_req = s;
    halt_req = h;
    div_ld   = l;
    div_val  = DIV_W'(v);
    edge_s   = s && !m_step_prev;
    a1       = m_age + 1;
    pulse    = 1'b0;
    nm       = m_mode;
    case (m_mode)
      M_IDLE: begin
        if (h)           nm = M_HALT;
        else if (r)      nm = M_RUN;
        else if (edge_s) nm = M_STEP;
      end
      M_RUN: begin
        if (h)                  nm = M_HALT;
        else if (!r)            nm = M_IDLE;
        else if (a1 % m_div == 0) pulse = 1'b1;
      end
      M_STEP: begin
        if (h) nm = M_HALT;
        else if (a1 == m_div) begin
          nm    = M_IDLE;
          pulse = 1'b1;
        end
      end
      default: begin
        if (!h && !r) nm = M_IDLE;
      end
    endcase
    if (l && (m_mode == M_IDLE || m_mode == M_HALT)) m_div = (v == 0) ? 1 : v;
    e.due = cyc + 1;
    e.en  = pulse;
    e.st  = mode_code(nm);
    e.cc  = m_pulses;
    q.push_back(e);
    m_pulses    = m_pulses + CNT_W'(pulse);
    m_age       = (nm == m_mode) ? a1 : 0;
    m_mode      = nm;
    m_step_prev = s;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0);
  endtask

  // Asynchronous reset away from any clock edge; outputs must clear at once.
  task automatic async_reset();
    #5;
    rst_n = 1'b0;
    #1;
    chk("rst_cpu_en", cpu_en, 0);
    chk("rst_state_o", state_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
`ifdef CYCLE_COUNT_EN
    chk("rst_cycle_cnt", cycle_cnt, 0);
`endif
    q.delete();
    model_reset();
    run_req  = 1'b0;
    step_req = 1'b0;
    halt_req = 1'b0;
    div_ld   = 1'b0;
    div_val  = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor: compare every expectation that falls due this cycle.
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      chk("sb_order", e.due, cyc);
      chk("cpu_en", cpu_en, e.en);
      chk("state_o", state_o, e.st);
      chk("busy", busy, (e.st == 2'b01) || (e.st == 2'b10));
      chk("halted", halted, e.st == 2'b11);
`ifdef CYCLE_COUNT_EN
      chk("cycle_cnt", cycle_cnt, e.cc);
`endif
    end
  end

  initial begin
    bit r;
    bit s;
    bit h;
    bit l;
    int v;

    run_req  = 1'b0;
    step_req = 1'b0;
    halt_req = 1'b0;
    div_ld   = 1'b0;
    div_val  = '0;
    rst_n    = 1'b1;
    model_reset();
    #1;
    rst_n = 1'b0;
    #1;
    chk("init_cpu_en", cpu_en, 0);
    chk("init_state_o", state_o, 0);
    chk("init_busy", busy, 0);
    chk("init_halted", halted, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Default divisor free run: pulses at +10, +20, +30.
    for (int i = 0; i < 35; i++) cycle(1, 0, 0, 0, 0);
    idle_cycles(3);

    // Single step with a second edge while stepping (dropped).
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    for (int i = 0; i < 12; i++) cycle(0, 0, 0, 0, 0);

    // Divisor 3, load attempt in RUN ignored, then divisor 0 -> every cycle.
    cycle(0, 0, 0, 1, 3);
    for (int i = 0; i < 8; i++) cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 1, 7);
    for (int i = 0; i < 8; i++) cycle(1, 0, 0, 0, 0);
    idle_cycles(2);
    cycle(0, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) cycle(1, 0, 0, 0, 0);
    idle_cycles(2);

    // Halt mid-period; run_req keeps HALTED, releasing both returns to IDLE.
    cycle(0, 0, 0, 1, 10);
    for (int i = 0; i < 6; i++) cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0);
    idle_cycles(2);

    // Halt coinciding with the tick: no pulse.
    cycle(0, 0, 0, 1, 3);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 1, 0, 0);
    idle_cycles(2);

    // Reset mid-RUN with a non-default divisor; divisor returns to 10.
    cycle(0, 0, 0, 1, 7);
    for (int i = 0; i < 7; i++) cycle(1, 0, 0, 0, 0);
    async_reset();
    for (int i = 0; i < 25; i++) cycle(1, 0, 0, 0, 0);
    idle_cycles(2);

    // Reset while a pulse is on cpu_en.
    cycle(0, 0, 0, 1, 2);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 0);
    async_reset();

    // Randomized traffic.
    r = 1'b0;
    s = 1'b0;
    h = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 11) == 0) r = !r;
      if (h) begin
        if ($urandom_range(0, 2) == 0) h = 1'b0;
      end else if ($urandom_range(0, 39) == 0) begin
        h = 1'b1;
      end
      if ($urandom_range(0, 3) == 0) s = !s;
      l = ($urandom_range(0, 9) == 0);
      v = int'($urandom_range(0, 5));
      cycle(r, s, h, l, v);
    end

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
    #1;
    chk("sb_drain", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
